fetch_mem_arbiter: RTL and testbench

Sequencer for the single shared memory port between instruction fetch and the MEM stage. Accepts fetch requests from the IF stage (PC of the current instruction) and load/store requests from the MEM stage, and serialises them onto one variable-latency external memory handshake. It generates the pipeline freeze signals, holding PC while a fetch is outstanding and stalling the whole pipe while a data access is outstanding. It also discards fetch data invalidated by a taken branch.

---
 rtl/fetch_mem_pkg.sv | 13 +
 rtl/watchdog_counter.sv | 35 +++
 rtl/fetch_mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_fetch_mem_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_mem_pkg.sv
// Shared types and default widths for the fetch/data memory-port arbiter.
package fetch_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/watchdog_counter.sv
// Counts enabled cycles since the last clear and raises a sticky flag once
// TIMEOUT cycles have elapsed; only reset drops the flag again.
module watchdog_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_reg;
    logic             expired_reg;

    // The count saturates at TIMEOUT so a hung memory cannot wrap it back to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg   <= '0;
            expired_reg <= 1'b0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != CNT_W'(TIMEOUT))) begin
            count_reg <= count_reg + CNT_W'(1);
            if (count_reg == CNT_W'(TIMEOUT - 1)) begin
                expired_reg <= 1'b1;
            end
        end
    end

    assign expired = expired_reg;

endmodule

// File: rtl/fetch_mem_arbiter.sv
// Serialises IF-stage fetches and MEM-stage loads/stores onto one external
// memory handshake and generates the pipeline freeze signals.
module fetch_mem_arbiter
    import fetch_mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_valid,
    output logic              ext_req,
    output logic              ext_we,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_wdata,
    input  logic [DATA_W-1:0] ext_rdata,
    input  logic              ext_ack,
    output logic              freeze_if,
    output logic              freeze_pipe,
    output logic              err
);

    arb_state_e        state_reg, state_next;
    logic [ADDR_W-1:0] ext_addr_reg;
    logic [DATA_W-1:0] ext_wdata_reg;
    logic              ext_we_reg;
    logic [DATA_W-1:0] if_rdata_reg;
    logic [DATA_W-1:0] mem_rdata_reg;
    logic              if_valid_reg;
    logic              mem_valid_reg;
    logic              discard_reg;

    logic data_req;
    logic accept_blocked;
    logic fetch_start;

    assign data_req       = mem_rd_en | mem_wr_en;
    // A requester that sees its valid pulse this cycle is advancing, so its
    // still-asserted level request must not start a second access.
    assign accept_blocked = if_valid_reg | mem_valid_reg;
    assign fetch_start    = if_req & ~if_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (!accept_blocked) begin
                    if (data_req) begin
                        state_next = DATA;
                    end else if (fetch_start) begin
                        state_next = FETCH;
                    end
                end
            end
            FETCH:   if (ext_ack) state_next = IDLE;
            DATA:    if (ext_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Freeze outputs are forced low while reset is asserted.
    always_comb begin
        ext_req     = 1'b0;
        freeze_pipe = 1'b0;
        freeze_if   = 1'b0;
        ext_req     = (state_reg != IDLE);
        freeze_pipe = rst & data_req & ~mem_valid_reg;
        freeze_if   = rst & ((if_req & ~if_valid_reg) | (data_req & ~mem_valid_reg));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_addr_reg  <= '0;
            ext_wdata_reg <= '0;
            ext_we_reg    <= 1'b0;
            if_rdata_reg  <= '0;
            mem_rdata_reg <= '0;
            if_valid_reg  <= 1'b0;
            mem_valid_reg <= 1'b0;
            discard_reg   <= 1'b0;
        end else begin
            if_valid_reg  <= 1'b0;
            mem_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    discard_reg <= 1'b0;
                    if (!accept_blocked) begin
                        if (data_req) begin
                            ext_addr_reg  <= mem_addr;
                            ext_wdata_reg <= mem_wdata;
                            ext_we_reg    <= mem_wr_en;
                        end else if (fetch_start) begin
                            ext_addr_reg  <= if_addr;
                            ext_wdata_reg <= '0;
                            ext_we_reg    <= 1'b0;
                        end
                    end
                end
                FETCH: begin
                    if (ext_ack) begin
                        if_rdata_reg <= ext_rdata;
                        if_valid_reg <= ~(discard_reg | if_flush);
                        discard_reg  <= 1'b0;
                    end else if (if_flush) begin
                        discard_reg <= 1'b1;
                    end
                end
                DATA: begin
                    if (ext_ack) begin
                        if (!ext_we_reg) begin
                            mem_rdata_reg <= ext_rdata;
                        end
                        mem_valid_reg <= 1'b1;
                    end
                end
                default: begin
                    discard_reg <= 1'b0;
                end
            endcase
        end
    end

    watchdog_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .enable (ext_req & ~ext_ack),
        .clear  (ext_ack),
        .expired(err)
    );

    assign ext_addr  = ext_addr_reg;
    assign ext_wdata = ext_wdata_reg;
    assign ext_we    = ext_we_reg;
    assign if_rdata  = if_rdata_reg;
    assign mem_rdata = mem_rdata_reg;
    assign if_valid  = if_valid_reg;
    assign mem_valid = mem_valid_reg;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Randomised scoreboard bench for fetch_mem_arbiter with a behavioural memory.
module tb_fetch_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk;
    logic          rst;
    logic          if_req, if_flush, if_valid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          mem_rd_en, mem_wr_en, mem_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          ext_req, ext_we, ext_ack;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata, ext_rdata;
    logic          freeze_if, freeze_pipe, err;

    fetch_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_ack(ext_ack),
        .freeze_if(freeze_if), .freeze_pipe(freeze_pipe), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } ext_txn_t;

    ext_txn_t    exp_ext[$];
    logic [31:0] exp_if[$];
    logic [31:0] exp_mem[$];

    // Reference view of memory and of the last load result seen by the MEM stage.
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] ref_last_load = '0;
    logic [31:0] ext_mem [logic [31:0]];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] ext_read(input logic [31:0] a);
        return ext_mem.exists(a) ? ext_mem[a] : init_val(a);
    endfunction

    int next_wait  = 0;
    bit hold_ack   = 1'b0;
    bit stray_ack  = 1'b0;

    // External memory: acks after next_wait extra cycles of ext_req.
    initial begin
        int wait_left;
        bit acked;
        wait_left = 0;
        acked     = 1'b0;
        ext_ack   = 1'b0;
        ext_rdata = '0;
        forever begin
            @(negedge clk);
            ext_ack = 1'b0;
            if (stray_ack) begin
                ext_ack   = 1'b1;
                ext_rdata = 32'hBAD0BAD0;
                stray_ack = 1'b0;
            end else if (ext_req && !acked && !hold_ack) begin
                if (wait_left == 0) begin
                    ext_ack = 1'b1;
                    acked   = 1'b1;
                    if (ext_we) begin
                        ext_mem[ext_addr] = ext_wdata;
                        ext_rdata = $urandom;
                    end else begin
                        ext_rdata = ext_read(ext_addr);
                    end
                end else begin
                    wait_left--;
                end
            end
            if (!ext_req) begin
                acked     = 1'b0;
                wait_left = next_wait;
            end
        end
    end

    // Request-side monitor: each new ext_req is matched against issue order.
    initial begin
        bit       prev;
        ext_txn_t t;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ext_req && !prev) begin
                $display("txn addr=%h we=%0d wdata=%h", ext_addr, ext_we, ext_wdata);
                if (exp_ext.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ext_unexpected actual=%h required=none", ext_addr);
                end else begin
                    t = exp_ext.pop_front();
                    check("ext_addr", ext_addr, t.addr);
                    check("ext_we", 32'(ext_we), 32'(t.we));
                    if (t.we) check("ext_wdata", ext_wdata, t.wdata);
                end
            end
            prev = ext_req;
        end
    end

    // Response-side monitor: each valid pulse must match a queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (if_valid) begin
                if (exp_if.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL if_valid_unexpected actual=%h required=none", if_rdata);
                end else begin
                    check("if_rdata", if_rdata, exp_if.pop_front());
                end
            end
            if (mem_valid) begin
                if (exp_mem.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_valid_unexpected actual=%h required=none", mem_rdata);
                end else begin
                    check("mem_rdata", mem_rdata, exp_mem.pop_front());
                end
            end
        end
    end

    task automatic wait_valid(input bit is_mem, output int k, output bit ok);
        k  = 0;
        ok = 1'b0;
        while (k < 200 && !ok) begin
            @(negedge clk);
            k++;
            ok = is_mem ? mem_valid : if_valid;
            if (!ok) begin
                if (is_mem) check("freeze_pipe_wait", 32'(freeze_pipe), 32'd1);
                else        check("freeze_if_wait", 32'(freeze_if), 32'd1);
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL valid_timeout actual=0 required=1");
        end
    endtask

    // mode 0: normal, 1: flush in first FETCH cycle, 2: flush in the ack cycle
    task automatic run_fetch(input logic [31:0] addr, input int w, input int mode);
        int k;
        bit ok;
        next_wait = w;
        @(posedge clk); #1;
        if_req  = 1'b1;
        if_addr = addr;
        exp_ext.push_back('{addr, 1'b0, 32'h0});
        if (mode == 0) begin
            exp_if.push_back(ref_read(addr));
            wait_valid(1'b0, k, ok);
            if (ok) begin
                check("if_latency", 32'(k), 32'(3 + w));
                check("freeze_if_valid_cycle", 32'(freeze_if), 32'd0);
            end
            @(posedge clk); #1;
            if_req = 1'b0;
        end else begin
            repeat ((mode == 1) ? 1 : w + 1) @(posedge clk);
            #1;
            if_flush = 1'b1;
            if_req   = 1'b0;
            @(posedge clk); #1;
            if_flush = 1'b0;
            repeat (w + 4) @(posedge clk);
            #1;
        end
    endtask

    task automatic queue_data(input bit is_store, input logic [31:0] addr, input logic [31:0] wdata);
        exp_ext.push_back('{addr, is_store, wdata});
        if (is_store) begin
            ref_mem[addr] = wdata;
        end else begin
            ref_last_load = ref_read(addr);
        end
        exp_mem.push_back(ref_last_load);
    endtask

    task automatic run_data(input bit is_store, input logic [31:0] addr, input logic [31:0] wdata, input int w);
        int k;
        bit ok;
        next_wait = w;
        @(posedge clk); #1;
        mem_rd_en = !is_store;
        mem_wr_en = is_store;
        mem_addr  = addr;
        mem_wdata = wdata;
        queue_data(is_store, addr, wdata);
        wait_valid(1'b1, k, ok);
        if (ok) begin
            check("mem_latency", 32'(k), 32'(3 + w));
            check("freeze_pipe_valid_cycle", 32'(freeze_pipe), 32'd0);
        end
        @(posedge clk); #1;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
    endtask

    // Fetch and data request raised together: data goes first, fetch follows.
    task automatic run_both(input logic [31:0] faddr, input bit is_store, input logic [31:0] daddr,
                            input logic [31:0] wdata, input int w);
        int k;
        bit ok;
        next_wait = w;
        @(posedge clk); #1;
        if_req    = 1'b1;
        if_addr   = faddr;
        mem_rd_en = !is_store;
        mem_wr_en = is_store;
        mem_addr  = daddr;
        mem_wdata = wdata;
        queue_data(is_store, daddr, wdata);
        exp_ext.push_back('{faddr, 1'b0, 32'h0});
        exp_if.push_back(ref_read(faddr));
        wait_valid(1'b1, k, ok);
        if (ok) begin
            check("both_mem_latency", 32'(k), 32'(3 + w));
            check("both_freeze_pipe", 32'(freeze_pipe), 32'd0);
            check("both_freeze_if", 32'(freeze_if), 32'd1);
        end
        @(posedge clk); #1;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        wait_valid(1'b0, k, ok);
        if (ok) check("both_fetch_latency", 32'(k), 32'(3 + w));
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    initial begin
        int kind;
        rst = 1'b0;
        if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        mem_rd_en = 1'b0; mem_wr_en = 1'b0; mem_addr = '0; mem_wdata = '0;

        repeat (2) @(negedge clk);
        check("rst_ext_req", 32'(ext_req), 32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        run_fetch(32'h10, 3, 0);
        run_both(32'h400, 1'b1, 32'h200, 32'hDEADBEEF, 1);
        run_fetch(32'h20, 3, 1);
        run_fetch(32'h24, 2, 2);
        run_fetch(32'h28, 0, 0);
        run_data(1'b1, 32'h44, 32'h12345678, 0);
        run_data(1'b0, 32'h44, 32'h0, 0);
        run_data(1'b1, 32'h48, 32'hCAFEF00D, 2);
        run_data(1'b0, 32'h200, 32'h0, 1);

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0: run_fetch(32'($urandom_range(0, 63)) << 2, $urandom_range(0, 5), 0);
                1: run_data(1'b0, 32'($urandom_range(0, 63)) << 2, 32'h0, $urandom_range(0, 5));
                2: run_data(1'b1, 32'($urandom_range(0, 63)) << 2, $urandom, $urandom_range(0, 5));
                3: run_fetch(32'($urandom_range(0, 63)) << 2, $urandom_range(2, 5), 1);
                4: run_fetch(32'($urandom_range(0, 63)) << 2, $urandom_range(0, 5), 2);
                default: run_both(32'($urandom_range(0, 63)) << 2, 1'($urandom_range(0, 1)),
                                  32'($urandom_range(0, 63)) << 2, $urandom, $urandom_range(0, 4));
            endcase
        end
        check("err_clear_normal", 32'(err), 32'd0);

        // Hung memory: watchdog fires, FSM keeps waiting, reset recovers.
        hold_ack = 1'b1;
        @(posedge clk); #1;
        if_req  = 1'b1;
        if_addr = 32'h300;
        exp_ext.push_back('{32'h300, 1'b0, 32'h0});
        repeat (TO) @(negedge clk);
        check("err_before_timeout", 32'(err), 32'd0);
        repeat (3) @(negedge clk);
        check("err_at_timeout", 32'(err), 32'd1);
        repeat (5) @(negedge clk);
        check("err_sticky", 32'(err), 32'd1);
        check("ext_req_held", 32'(ext_req), 32'd1);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("arst_ext_req", 32'(ext_req), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        check("arst_freeze_if", 32'(freeze_if), 32'd0);
        check("arst_ext_addr", ext_addr, 32'd0);
        check("arst_mem_rdata", mem_rdata, 32'd0);
        if_req   = 1'b0;
        hold_ack = 1'b0;
        ref_last_load = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        stray_ack = 1'b1;
        repeat (3) @(negedge clk);
        check("stray_ack_ignored", 32'(ext_req), 32'd0);
        run_fetch(32'h500, 1, 0);
        run_data(1'b0, 32'h44, 32'h0, 0);

        repeat (4) @(posedge clk);
        check("exp_ext_drained", 32'(exp_ext.size()), 32'd0);
        check("exp_if_drained", 32'(exp_if.size()), 32'd0);
        check("exp_mem_drained", 32'(exp_mem.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
